// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam int PORT_IF    = 0;
    localparam int PORT_LS    = 1;
    localparam int BYTE_OFF_W = 2;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter; master = requesters/memory, slave = arbiter.
interface mem_arb_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int BADDR_WIDTH = ADDR_WIDTH + 2
);
    logic                   m0_req;
    logic                   m0_we;
    logic [BADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0]  m0_wdata;
    logic                   m0_gnt;
    logic                   m0_rvalid;
    logic [DATA_WIDTH-1:0]  m0_rdata;
    logic                   m0_err;

    logic                   m1_req;
    logic                   m1_we;
    logic [BADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0]  m1_wdata;
    logic                   m1_gnt;
    logic                   m1_rvalid;
    logic [DATA_WIDTH-1:0]  m1_rdata;
    logic                   m1_err;

    logic                   mem_wr_en;
    logic                   mem_rd_en;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0]  mem_wdata;
    logic [DATA_WIDTH-1:0]  mem_rdata;

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
        input  mem_wr_en, mem_rd_en, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata, m1_err,
        output mem_wr_en, mem_rd_en, mem_addr, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin selector; ptr names the port granted most recently.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       en,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[0] && (!req[1] || ptr)) begin
                gnt[0] = 1'b1;
            end else if (req[1]) begin
                gnt[1] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch and a load/store port onto one single-ported
// memory with a registered read path; one read outstanding at a time.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_DEPTH   = 20,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = $clog2(MEM_DEPTH),
    parameter int BADDR_WIDTH = ADDR_WIDTH + 2
) (
    input  logic     clk,
    input  logic     rst,
    mem_arb_if.slave bus
);

    state_t                 state;
    state_t                 state_nxt;
    logic                   last_gnt;
    logic                   owner;
    logic [1:0]             gnt;
    logic                   any_gnt;
    logic                   sel;
    logic                   sel_we;
    logic [BADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic [ADDR_WIDTH-1:0]  word;
    logic                   bad;

    rr_arb2 u_rr (
        .req ({bus.m1_req, bus.m0_req}),
        .en  (state == IDLE && !rst),
        .ptr (last_gnt),
        .gnt (gnt)
    );

    always_comb begin
        any_gnt   = |gnt;
        sel       = gnt[PORT_LS];
        sel_we    = sel ? bus.m1_we    : bus.m0_we;
        sel_addr  = sel ? bus.m1_addr  : bus.m0_addr;
        sel_wdata = sel ? bus.m1_wdata : bus.m0_wdata;
        word      = ADDR_WIDTH'(sel_addr >> BYTE_OFF_W);
        // Rejected accesses are still granted but never reach the memory.
        bad       = (sel_addr[BYTE_OFF_W-1:0] != '0) ||
                    (32'(sel_addr >> BYTE_OFF_W) >= 32'(MEM_DEPTH));
        state_nxt = state;
        case (state)
            IDLE:    if (any_gnt && !sel_we && !bad) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.m0_gnt    = gnt[PORT_IF];
    assign bus.m1_gnt    = gnt[PORT_LS];
    assign bus.mem_wr_en = any_gnt &&  sel_we && !bad;
    assign bus.mem_rd_en = any_gnt && !sel_we && !bad;
    assign bus.mem_addr  = word;
    assign bus.mem_wdata = sel_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            last_gnt      <= 1'(PORT_LS);
            owner         <= 1'(PORT_IF);
            bus.m0_rvalid <= 1'b0;
            bus.m1_rvalid <= 1'b0;
            bus.m0_err    <= 1'b0;
            bus.m1_err    <= 1'b0;
            bus.m0_rdata  <= '0;
            bus.m1_rdata  <= '0;
        end else begin
            state <= state_nxt;
            if (any_gnt) begin
                last_gnt <= sel;
                owner    <= sel;
            end
            bus.m0_err    <= any_gnt && bad && (sel == 1'(PORT_IF));
            bus.m1_err    <= any_gnt && bad && (sel == 1'(PORT_LS));
            // Response stage: memory data is valid during RESP and is routed by the owner bit.
            bus.m0_rvalid <= (state == RESP) && (owner == 1'(PORT_IF));
            bus.m1_rvalid <= (state == RESP) && (owner == 1'(PORT_LS));
            if (state == RESP && owner == 1'(PORT_IF)) bus.m0_rdata <= bus.mem_rdata;
            if (state == RESP && owner == 1'(PORT_LS)) bus.m1_rdata <= bus.mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;

    localparam int DEPTH = 20;
    localparam int DW    = 32;
    localparam int AW    = $clog2(DEPTH);
    localparam int BAW   = AW + 2;

    typedef struct {
        int          port;
        bit          is_err;
        logic [31:0] data;
        int          due;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    mem_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BADDR_WIDTH(BAW)) bus ();

    mem_arbiter #(.MEM_DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BADDR_WIDTH(BAW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(int i);
        return 32'hA500_0000 | (32'(i) * 32'h0000_0101);
    endfunction

    // External memory with registered read data
    logic [31:0] mem [0:31];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
            bus.mem_rdata <= '0;
        end else begin
            if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
            if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    // Reference model: arbitration, memory contents, expected responses
    rsp_t        sbq[$];
    logic [31:0] model_mem [0:31];
    int          model_last = 1;
    bit          model_block = 0;

    always @(negedge clk) begin : predictor
        logic [1:0]     eg;
        int             w;
        bit             we, bad;
        logic [BAW-1:0] a;
        logic [31:0]    wd;
        int             wrd;
        eg = 2'b00;
        w  = 0;
        if (rst) begin
            model_last  = 1;
            model_block = 0;
            for (int i = 0; i < 32; i++) model_mem[i] = init_word(i);
        end else if (model_block) begin
            model_block = 0;
        end else if (bus.m0_req || bus.m1_req) begin
            if (bus.m0_req && bus.m1_req) w = 1 - model_last;
            else                          w = bus.m0_req ? 0 : 1;
            eg[w] = 1'b1;
        end
        check("gnt", {30'd0, bus.m1_gnt, bus.m0_gnt}, {30'd0, eg});
        if (eg != 2'b00) begin
            we  = (w == 1) ? bus.m1_we    : bus.m0_we;
            a   = (w == 1) ? bus.m1_addr  : bus.m0_addr;
            wd  = (w == 1) ? bus.m1_wdata : bus.m0_wdata;
            wrd = int'(a) / 4;
            bad = (int'(a) % 4 != 0) || (wrd >= DEPTH);
            check("strobes", {30'd0, bus.mem_wr_en, bus.mem_rd_en}, {30'd0, !bad && we, !bad && !we});
            if (!bad) check("mem_addr", 32'(bus.mem_addr), 32'(wrd));
            if (!bad && we) begin
                check("mem_wdata", bus.mem_wdata, wd);
                model_mem[wrd] = wd;
            end
            if (bad) begin
                sbq.push_back('{w, 1'b1, 32'h0, cyc + 1});
            end else if (!we) begin
                sbq.push_back('{w, 1'b0, model_mem[wrd], cyc + 2});
                model_block = 1;
            end
            model_last = w;
        end else begin
            check("strobes_idle", {30'd0, bus.mem_wr_en, bus.mem_rd_en}, 32'd0);
        end
    end

    logic [31:0] exp_rd [2];

    always @(negedge clk) begin : monitor
        logic [3:0] ev, ov;
        rsp_t       r;
        ov = {bus.m1_err, bus.m1_rvalid, bus.m0_err, bus.m0_rvalid};
        if (rst) begin
            sbq.delete();
            exp_rd[0] = '0;
            exp_rd[1] = '0;
            check("reset_pulses", {28'd0, ov}, 32'd0);
            check("reset_rdata", bus.m0_rdata | bus.m1_rdata, 32'd0);
        end else begin
            ev = 4'b0000;
            while (sbq.size() > 0 && sbq[0].due < cyc) begin
                r = sbq.pop_front();
                checks++;
                errors++;
                $display("FAIL rsp_missing port=%0d act=none exp_cyc=%0d cyc=%0d", r.port, r.due, cyc);
            end
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                r = sbq.pop_front();
                ev[r.port * 2 + (r.is_err ? 1 : 0)] = 1'b1;
                if (!r.is_err) exp_rd[r.port] = r.data;
            end
            check("rsp_pulses", {28'd0, ov}, {28'd0, ev});
            check("m0_rdata", bus.m0_rdata, exp_rd[0]);
            check("m1_rdata", bus.m1_rdata, exp_rd[1]);
        end
    end

    // Stimulus: per-port pending transactions held until granted
    bit          pend [2];
    int          age [2];
    logic        tx_we [2];
    logic [BAW-1:0] tx_addr [2];
    logic [31:0] tx_wdata [2];
    int          glog[$];

    task automatic tick();
        bus.m0_req   = pend[0];
        bus.m0_we    = tx_we[0];
        bus.m0_addr  = tx_addr[0];
        bus.m0_wdata = tx_wdata[0];
        bus.m1_req   = pend[1];
        bus.m1_we    = tx_we[1];
        bus.m1_addr  = tx_addr[1];
        bus.m1_wdata = tx_wdata[1];
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            if (pend[p]) begin
                if ((p == 0 && bus.m0_gnt) || (p == 1 && bus.m1_gnt)) begin
                    pend[p] = 0;
                    glog.push_back(p);
                end else begin
                    age[p]++;
                    if (age[p] > 40) begin
                        checks++;
                        errors++;
                        $display("FAIL grant_timeout port=%0d waited=%0d limit=40", p, age[p]);
                        pend[p] = 0;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start(int p, logic we, logic [BAW-1:0] a, logic [31:0] d);
        tx_we[p]    = we;
        tx_addr[p]  = a;
        tx_wdata[p] = d;
        pend[p]     = 1;
        age[p]      = 0;
    endtask

    task automatic wait_done(int p);
        while (pend[p]) tick();
    endtask

    function automatic logic [BAW-1:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return BAW'($urandom_range(0, 19) * 4 + $urandom_range(1, 3));
            1:       return BAW'($urandom_range(20, 31) * 4);
            default: return BAW'($urandom_range(0, 19) * 4);
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d limit=50000", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; age[p] = 0; tx_we[p] = 0; tx_addr[p] = '0; tx_wdata[p] = '0;
        end
        // Requests held during reset must not be granted
        bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = BAW'(4); bus.m1_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;

        // Contention from reset: both read continuously
        glog.delete();
        for (int i = 0; i < 14; i++) begin
            if (!pend[0]) start(0, 0, BAW'(0), 32'h0);
            if (!pend[1]) start(1, 0, BAW'(4), 32'h0);
            tick();
        end
        wait_done(0);
        wait_done(1);
        check("contention_grants", 32'(glog.size() >= 4), 32'd1);
        if (glog.size() >= 4) begin
            for (int i = 0; i < 4; i++) check("contention_order", 32'(glog[i]), 32'(i % 2));
        end
        repeat (3) tick();

        // Single read of byte 0x08
        start(0, 0, BAW'(8), 32'h0);
        wait_done(0);
        repeat (3) tick();

        // Write then read
        start(1, 1, BAW'('h10), 32'hDEAD_BEEF);
        wait_done(1);
        tick();
        check("mem_word4", mem[4], 32'hDEAD_BEEF);
        start(0, 0, BAW'('h10), 32'h0);
        wait_done(0);
        repeat (3) tick();

        // Misaligned and out-of-range requests
        start(1, 0, BAW'('h06), 32'h0);
        wait_done(1);
        repeat (2) tick();
        start(0, 0, BAW'('h50), 32'h0);
        wait_done(0);
        repeat (2) tick();

        // Reset during the response cycle of a read
        start(0, 0, BAW'('h0C), 32'h0);
        wait_done(0);
        rst = 1;
        tick();
        rst = 0;
        repeat (2) tick();
        glog.delete();
        start(0, 0, BAW'(0), 32'h0);
        start(1, 0, BAW'(4), 32'h0);
        wait_done(0);
        wait_done(1);
        check("post_reset_first", glog.size() > 0 ? 32'(glog[0]) : 32'hFFFF_FFFF, 32'd0);
        repeat (3) tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0)
                    start(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            end
            tick();
        end
        wait_done(0);
        wait_done(1);
        repeat (6) tick();
        check("sb_drained", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 20: memory depth in 32-bit words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data word width.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(MEM_DEPTH): memory word-address width.
REQ-004 SHALL have parameter BADDR_WIDTH, default ADDR_WIDTH+2: requester byte-address width.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 SHALL have these clock and reset ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
REQ-007 SHALL have these ports per requester, for N = 0 and N = 1 (port 0 is instruction fetch, port 1 is load/store):
- mN_req  input  1  access request, held until granted
- mN_we  input  1  1 = write, 0 = read
- mN_addr  input  BADDR_WIDTH  byte address
- mN_wdata  input  DATA_WIDTH  write data
- mN_gnt  output  1  request accepted this cycle
- mN_rvalid  output  1  read data valid, one-cycle pulse
- mN_rdata  output  DATA_WIDTH  read data
- mN_err  output  1  access rejected, one-cycle pulse
REQ-008 SHALL have these memory-side ports:
- mem_wr_en  output  1  memory write strobe
- mem_rd_en  output  1  memory read strobe
- mem_addr  output  ADDR_WIDTH  word address
- mem_wdata  output  DATA_WIDTH  write data
- mem_rdata  input  DATA_WIDTH  registered memory read data

Function
REQ-009 SHALL implement an FSM with two states: IDLE (grants allowed) and RESP (read outstanding, no grant).
REQ-010 In IDLE, SHALL grant exactly one requesting port per cycle; mN_gnt is combinational from mN_req, the state and the arbitration pointer.
REQ-011 Arbitration SHALL be round-robin: with only one port requesting, grant it; with both requesting, grant the port not granted most recently.
REQ-012 The last-grant pointer SHALL update only on a grant.
REQ-013 Word address SHALL be mN_addr >> 2, presented on mem_addr in the grant cycle.
REQ-014 A write grant SHALL assert mem_wr_en with mem_wdata = mN_wdata for exactly that cycle; completion is the grant itself; state stays IDLE.
REQ-015 A read grant in cycle N SHALL:
- assert mem_rd_en in cycle N
- enter RESP in N+1
- capture mem_rdata at the end of N+1
- pulse mN_rvalid with mN_rdata in N+2
- return to IDLE in N+2, so a new grant may coincide with the rvalid pulse
REQ-016 mN_rdata SHALL hold its last value when rvalid is low.
REQ-017 A misaligned request (mN_addr[1:0] != 0) or an out-of-range request (word address >= MEM_DEPTH) SHALL:
- be granted normally
- issue no memory strobe
- pulse mN_err in the cycle after the grant
- remain in IDLE
REQ-018 mem_wr_en and mem_rd_en SHALL never both be high; at most one strobe per cycle.
REQ-019 In RESP, both mN_gnt SHALL be low regardless of requests.
REQ-020 Port-1 rvalid/err pulses SHALL never target port 0, and vice versa; responses route by a registered owner bit.

Reset
REQ-021 When rst is high, the following SHALL apply asynchronously:
- state = IDLE
- last-grant pointer = port 1, so port 0 wins the first contention
- all mN_rvalid and mN_err = 0
- all mN_rdata = 0
REQ-022 Reset asserted while in RESP SHALL discard the outstanding read; no rvalid pulse follows.
REQ-023 mN_gnt, mem_wr_en and mem_rd_en SHALL be 0 while rst is high.

Structure
REQ-024 A shared package mem_arb_pkg SHALL hold:
- the state typedef (IDLE, RESP)
- the port-index constants PORT_IF = 0 and PORT_LS = 1
- the byte-offset width constant (2)
REQ-025 Round-robin selection SHALL be a sub-module rr_arb2 (inputs: two requests, enable, pointer; outputs: one-hot grant).
REQ-026 The memory SHALL be instantiated outside this block; the arbiter only drives its strobes, address and data.

Verification
REQ-027 Single read: m0 reads 0x08 -> gnt cycle N, mem_rd_en with mem_addr=2 in N, m0_rvalid in N+2 with m0_rdata=mem[2].
REQ-028 Contention: both ports continuously read 0x00 and 0x04 from reset -> grants alternate 0,1,0,1; each rvalid goes to the correct port; no grant occurs in RESP cycles.
REQ-029 Write then read: m1 writes 0xDEADBEEF to 0x10, then m0 reads 0x10 -> mem_wr_en with addr 4 for one cycle; m0_rdata=0xDEADBEEF.
REQ-030 Errors: m1 reads 0x06 -> m1_err pulses, no strobe; m0 reads 0x50 (word 20, MEM_DEPTH=20) -> m0_err, no strobe.
REQ-031 Reset mid-read: rst asserted in the RESP cycle -> no m0_rvalid afterwards; state IDLE; the next contention goes to port 0.
